mul_seq: RTL and testbench

- Multi-cycle sequencer that produces the full 2*XLEN product of two XLEN operands using one XLEN/2 x XLEN/2 unsigned multiplier.
- The multiplier is used over four cycles, followed by one signed-correction cycle.
- Area-reduced alternative to the single-cycle partial-product multiplier in the MDU.
- Sits in the MDU: a Start from the Execute stage raises BusyE to stall the pipeline, and the result is presented with DoneM.

---
 rtl/mul_seq_pkg.sv | 37 +++
 rtl/mul_seq_half.sv | 13 +
 rtl/mul_seq.sv | 140 ++++++++++++++
 tb/tb_mul_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding, Funct3 codes, counter width and signed-correction selection.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } mulseq_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam int CNT_W = 2;

  // Which operand sign bits trigger a subtraction at the XLEN shift.
  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } corr_sel_t;

  function automatic corr_sel_t corr_sel(input logic [2:0] f3);
    corr_sel_t s;
    s = '0;
    case (f3)
      F3_MULH:           s = '{a_signed: 1'b1, b_signed: 1'b1};
      F3_MULHSU:         s = '{a_signed: 1'b1, b_signed: 1'b0};
      F3_MUL, F3_MULHU:  s = '0;
      default:           s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_seq_half.sv
// Purely combinational H x H unsigned multiplier.
// Kept in its own module so it can be swapped for a technology macro.
module mul_half #(
  parameter int H = 16
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-1:0] p
);

  assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/mul_seq.sv
// Four-cycle sequential XLEN x XLEN multiplier with one signed-correction cycle.
// Optional macro MUL_SEQ_EARLY_EXIT_EN: skip counts 1..3 when both upper halves are zero.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StartE,
  input  logic              FlushE,
  input  logic              StallM,
  input  logic [XLEN-1:0]   ForwardedSrcAE,
  input  logic [XLEN-1:0]   ForwardedSrcBE,
  input  logic [2:0]        Funct3E,
  output logic              BusyE,
  output logic              DoneM,
  output logic [2*XLEN-1:0] ProdM
);

  localparam int H  = XLEN / 2;
  localparam int PW = 2 * XLEN;

  mulseq_state_t    state, state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  a_q, b_q;
  logic [2:0]       f3_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    prod;

  logic             start_ok;
  logic             last_mul;
  logic [H-1:0]     mul_a, mul_b;
  logic [XLEN-1:0]  pp;
  logic [PW-1:0]    pp_ext, pp_shifted;
  logic [PW-1:0]    corr_term;
  corr_sel_t        sel;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic ahi_z, bhi_z;
`endif

  assign start_ok = StartE & ~FlushE;

  // Counter bit 0 picks the A half, bit 1 picks the B half.
  assign mul_a = count[0] ? a_q[XLEN-1:H] : a_q[H-1:0];
  assign mul_b = count[1] ? b_q[XLEN-1:H] : b_q[H-1:0];

  mul_half #(.H(H)) u_mul_half (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  assign pp_ext = {{XLEN{1'b0}}, pp};

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pp_shifted = '0;
    unique case (count)
      2'd0:       pp_shifted = pp_ext;
      2'd1, 2'd2: pp_shifted = pp_ext << H;
      default:    pp_shifted = pp_ext << XLEN;
    endcase
  end

  // Signed operands contribute -sign*other at the XLEN shift.
  assign sel       = corr_sel(f3_q);
  assign corr_term = ({PW{sel.a_signed & a_q[XLEN-1]}} & {b_q, {XLEN{1'b0}}})
                   + ({PW{sel.b_signed & b_q[XLEN-1]}} & {a_q, {XLEN{1'b0}}});

`ifdef MUL_SEQ_EARLY_EXIT_EN
  assign last_mul = (count == '1) | ((count == '0) & ahi_z & bhi_z);
`else
  assign last_mul = (count == '1);
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = MUL;
      MUL:     if (last_mul) state_next = CORR;
      CORR:    state_next = DONE;
      DONE:    if (!StallM)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (FlushE) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      prod  <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      ahi_z <= 1'b0;
      bhi_z <= 1'b0;
`endif
    end else if (FlushE) begin
      count <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (StartE) begin
            a_q   <= ForwardedSrcAE;
            b_q   <= ForwardedSrcBE;
            f3_q  <= Funct3E;
            acc   <= '0;
            count <= '0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
            ahi_z <= (ForwardedSrcAE[XLEN-1:H] == '0);
            bhi_z <= (ForwardedSrcBE[XLEN-1:H] == '0);
`endif
          end
        end
        MUL: begin
          acc   <= acc + pp_shifted;
          count <= last_mul ? '0 : count + 1'b1;
        end
        CORR:    prod <= acc - corr_term;
        default: ;
      endcase
    end
  end

  assign BusyE = (state == IDLE & start_ok) | (state == MUL) | (state == CORR);
  assign DoneM = (state == DONE);
  assign ProdM = prod;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq at XLEN=32; early-exit latency follows
// MUL_SEQ_EARLY_EXIT_EN when the bench is built with it.
module tb_mul_seq;
  import mul_seq_pkg::*;

  localparam int XLEN = 32;
`ifdef MUL_SEQ_EARLY_EXIT_EN
  localparam int EE_DONE = 3;
`else
  localparam int EE_DONE = 6;
`endif

  logic        clk = 1'b0;
  logic        reset, StartE, FlushE, StallM;
  logic [31:0] A, B;
  logic [2:0]  F3;
  logic        BusyE, DoneM;
  logic [63:0] ProdM;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .StartE         (StartE),
    .FlushE         (FlushE),
    .StallM         (StallM),
    .ForwardedSrcAE (A),
    .ForwardedSrcBE (B),
    .Funct3E        (F3),
    .BusyE          (BusyE),
    .DoneM          (DoneM),
    .ProdM          (ProdM)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Starts in the current IDLE cycle (cycle 0); returns in the DONE cycle.
  task automatic do_mult(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int done_cyc, input logic [63:0] exp);
    StartE = 1'b1; F3 = f3; A = a; B = b;
    settle();
    check($sformatf("%s busy c0", tag), BusyE, 1);
    for (int c = 1; c <= done_cyc; c++) begin
      tick();
      StartE = 1'b0; A = $urandom; B = $urandom; F3 = 3'($urandom);
      settle();
      if (c < done_cyc) begin
        check($sformatf("%s busy c%0d", tag, c), BusyE, 1);
        check($sformatf("%s done c%0d", tag, c), DoneM, 0);
      end else begin
        check($sformatf("%s busy c%0d", tag, c), BusyE, 0);
        check($sformatf("%s done c%0d", tag, c), DoneM, 1);
        check($sformatf("%s prod", tag), ProdM, exp);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; StartE = 1'b0; FlushE = 1'b0; StallM = 1'b0;
    A = '0; B = '0; F3 = '0;
    tick(); tick();
    check("rst busy", BusyE, 0);
    check("rst done", DoneM, 0);
    check("rst prod", ProdM, 64'h0);
    reset = 1'b0;
    tick();

    do_mult("mulhu_ff", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 64'hFFFFFFFE00000001);
    tick(); settle();
    check("mulhu_ff idle done", DoneM, 0);
    do_mult("mulh_ff", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 64'h0000000000000001);
    tick();
    do_mult("mulh_min", F3_MULH, 32'h80000000, 32'h80000000, 6, 64'h4000000000000000);
    tick();
    do_mult("mulhu_parts", F3_MULHU, 32'h00020003, 32'h00050007, 6, 64'h0000000A001D0015);
    tick();
    do_mult("mul_neg", F3_MUL, 32'hFFFFFFFF, 32'h00000005, 6, 64'h00000004FFFFFFFB);
    tick();
    do_mult("mulhsu_ff", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 64'hFFFFFFFF00000001);
    tick();

    // Flush together with Start: no capture, stays idle.
    StartE = 1'b1; FlushE = 1'b1; F3 = F3_MUL; A = 32'd3; B = 32'd5;
    settle();
    check("flush+start busy", BusyE, 0);
    tick();
    StartE = 1'b0; FlushE = 1'b0;
    settle();
    check("flush+start busy next", BusyE, 0);
    check("flush+start done next", DoneM, 0);
    check("flush+start prod", ProdM, 64'hFFFFFFFF00000001);

    // Abort in cycle 3, restart in cycle 4.
    StartE = 1'b1; F3 = F3_MUL; A = 32'd7; B = 32'd9;
    tick();
    StartE = 1'b0;
    tick();
    tick();
    FlushE = 1'b1;
    settle();
    check("abort busy c3", BusyE, 1);
    tick();
    FlushE = 1'b0;
    settle();
    check("abort busy c4", BusyE, 0);
    check("abort done c4", DoneM, 0);
    check("abort prod kept", ProdM, 64'hFFFFFFFF00000001);
    do_mult("restart", F3_MUL, 32'd3, 32'd5, 6, 64'd15);

    // Stall holds DONE for three cycles; a Start during DONE is ignored.
    StallM = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      StartE = (k == 2); A = 32'd11; B = 32'd13; F3 = F3_MUL;
      if (k == 3) StallM = 1'b0;
      settle();
      check($sformatf("stall done k%0d", k), DoneM, 1);
      check($sformatf("stall prod k%0d", k), ProdM, 64'd15);
      check($sformatf("stall busy k%0d", k), BusyE, 0);
    end
    tick(); settle();
    check("release done", DoneM, 0);
    check("release busy", BusyE, 0);
    check("release prod", ProdM, 64'd15);

    // Reset in the middle of an operation.
    StartE = 1'b1; F3 = F3_MULHU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    tick();
    StartE = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("midrst busy", BusyE, 0);
    check("midrst done", DoneM, 0);
    check("midrst prod", ProdM, 64'h0);
    do_mult("post_rst", F3_MULHU, 32'h00020003, 32'h00050007, 6, 64'h0000000A001D0015);
    tick();

    // Small operands: early exit when enabled, full latency otherwise.
    do_mult("ee_small", F3_MUL, 32'd3, 32'd5, EE_DONE, 64'd15);
    tick();
    do_mult("ee_hi_set", F3_MUL, 32'h00010000, 32'd5, 6, 64'h0000000000050000);

    // Flush while in DONE under stall: leave DONE, product kept.
    StallM = 1'b1; FlushE = 1'b1;
    tick();
    StallM = 1'b0; FlushE = 1'b0;
    settle();
    check("flush done", DoneM, 0);
    check("flush done prod", ProdM, 64'h0000000000050000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
